// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter in front of one iterative shift-and-add multiplier.
// Two requesters share the unit; each product is returned tagged with its owner's ID.
module mult_share_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_p,
    output logic               res_id,
    output logic               busy
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  mcand_q, mcand_d;
    logic [PW-1:0]  acc_q, acc_d;
    logic [PW-1:0]  res_p_q, res_p_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           id_q, id_d;
    logic           res_id_q, res_id_d;
    logic           last_grant_q, last_grant_d;
    logic           grant;
    logic           any_valid;
    logic           accept_ok;
    logic [PW-1:0]  step_sum;

    assign any_valid = req0_valid | req1_valid;
    // Contention goes to whoever was not served last; a lone requester always wins.
    assign grant     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign accept_ok = (state_q == IDLE) && any_valid && !rst;

    assign req0_ready = accept_ok && !grant;
    assign req1_ready = accept_ok &&  grant;
    assign res_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign res_p      = res_p_q;
    assign res_id     = res_id_q;

    assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no path through the case can infer a latch.
        state_d      = state_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        res_p_d      = res_p_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, (grant ? req1_a : req0_a)};
                    mplier_d = grant ? req1_b : req0_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    id_d     = grant;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = step_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Fixed WIDTH steps: zero operands still take the full latency.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    res_p_d  = step_sum;
                    res_id_d = id_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    last_grant_d = id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop updates from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            id_q         <= 1'b0;
            res_p_q      <= '0;
            res_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            res_p_q      <= res_p_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
